// File: rtl/hh_gating_if.sv
// hh_gating_if: handshake + configuration bundle for hh_gating_engine.
//   master : drives start/v_in and the cfg_* write port, observes busy/done/g_out
//   slave  : the engine side
// W, N_CH and LUT_BITS must match the engine instance connected to it.
interface hh_gating_if #(
  parameter int W        = 16,
  parameter int N_CH     = 4,
  parameter int LUT_BITS = 6,
  parameter int CHW      = (N_CH > 1) ? $clog2(N_CH) : 1
);
  logic                start;
  logic [W-1:0]        v_in;
  logic                busy;
  logic                done;
  logic                cfg_we;
  logic [1:0]          cfg_sel;
  logic [CHW-1:0]      cfg_ch;
  logic [LUT_BITS-1:0] cfg_addr;
  logic [W-1:0]        cfg_data;
  logic [N_CH*W-1:0]   g_out;

  modport master (output start, v_in, cfg_we, cfg_sel, cfg_ch, cfg_addr, cfg_data,
                  input  busy, done, g_out);
  modport slave  (input  start, v_in, cfg_we, cfg_sel, cfg_ch, cfg_addr, cfg_data,
                  output busy, done, g_out);
endinterface

// File: rtl/hh_gating_engine.sv
// hh_gating_engine: time-multiplexed Hodgkin-Huxley gating integrator.
// Each accepted start advances every channel one forward-Euler step:
//   g += dt * (alpha(V)*(1-g) - beta(V)*g),  dt = 2^-DT_SHIFT
// alpha/beta come from per-channel runtime-writable LUTs indexed by V.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   bus.start     request a step (IDLE only); bus.v_in latched with it
//   bus.busy      high in every non-IDLE state
//   bus.done      one-cycle pulse after the last channel is written
//   bus.cfg_*     LUT / g-state write port, ignored while busy
//   bus.g_out     packed gating states, channel c at [c*W +: W]
// Each channel takes three cycles: LOOKUP, MUL, UPD.
module hh_gating_engine #(
  parameter int W        = 16,
  parameter int FRAC     = 12,
  parameter int N_CH     = 4,
  parameter int LUT_BITS = 6,
  parameter int V_MIN    = -80,
  parameter int V_SHIFT  = 2,
  parameter int DT_SHIFT = 4
) (
  input  logic         clk,
  input  logic         rst,
  hh_gating_if.slave   bus
);
  localparam int CHW     = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int DEPTH   = 1 << LUT_BITS;
  localparam int SW      = 2*W + 2;
  localparam logic [W-1:0]          ONE     = W'(1 << FRAC);
  localparam logic signed [SW-1:0]  ONE_S   = SW'(1 << FRAC);
  localparam logic signed [W:0]     VMIN_S  = (W+1)'(V_MIN);
  localparam logic signed [W:0]     IDX_MAX = (W+1)'(DEPTH - 1);

  typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_MUL, S_UPD, S_DONE} state_t;

  state_t                  state_q;
  logic [CHW-1:0]          ch_q;
  logic signed [W-1:0]     v_q;
  logic [N_CH-1:0][W-1:0]  g_q;
  logic [W-1:0]            a_q, b_q, gc_q;
  logic [2*W-1:0]          p_q, q_q;
  logic                    busy_q, done_q;

  logic [W-1:0] alpha_mem [N_CH][DEPTH];
  logic [W-1:0] beta_mem  [N_CH][DEPTH];

  // Config writes only land while idle; the same edge may also accept start,
  // so the step sees the freshly written value.
  logic cfg_ok;
  assign cfg_ok = bus.cfg_we && !busy_q;

  // LUT storage: no reset, contents undefined until written.
  always_ff @(posedge clk) begin
    if (!rst && cfg_ok) begin
      if (bus.cfg_sel == 2'd0) alpha_mem[bus.cfg_ch][bus.cfg_addr] <= bus.cfg_data;
      if (bus.cfg_sel == 2'd1) beta_mem[bus.cfg_ch][bus.cfg_addr]  <= bus.cfg_data;
    end
  end

  // Voltage index: (V - V_MIN) >>> V_SHIFT in W+1 signed bits, clamped to the table.
  logic signed [W:0]   vdiff, vsh;
  logic [LUT_BITS-1:0] idx;
  always_comb begin
    vdiff = (W+1)'(v_q) - VMIN_S;
    vsh   = vdiff >>> V_SHIFT;
    idx   = vsh[LUT_BITS-1:0];
    if (vsh < 0)            idx = '0;
    else if (vsh > IDX_MAX) idx = LUT_BITS'(DEPTH - 1);
  end

  // Update: step = (P - Q) >>> (FRAC+DT_SHIFT) floors toward -inf; the sum is
  // carried wide enough that nothing wraps before the [0, ONE] clamp.
  logic signed [2*W:0]  d_s, step_s;
  logic signed [SW-1:0] sum_s;
  logic [W-1:0]         g_new;
  always_comb begin
    d_s    = $signed({1'b0, p_q}) - $signed({1'b0, q_q});
    step_s = d_s >>> (FRAC + DT_SHIFT);
    sum_s  = SW'(step_s) + SW'($signed({1'b0, gc_q}));
    g_new  = sum_s[W-1:0];
    if (sum_s < 0)          g_new = '0;
    else if (sum_s > ONE_S) g_new = ONE;
  end

  logic [W-1:0] cfg_g;
  assign cfg_g = (bus.cfg_data > ONE) ? ONE : bus.cfg_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      ch_q    <= '0;
      v_q     <= '0;
      g_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      gc_q    <= '0;
      p_q     <= '0;
      q_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cfg_ok && bus.cfg_sel == 2'd2) g_q[bus.cfg_ch] <= cfg_g;
          if (bus.start) begin
            v_q     <= $signed(bus.v_in);
            ch_q    <= '0;
            busy_q  <= 1'b1;
            state_q <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          a_q     <= alpha_mem[ch_q][idx];
          b_q     <= beta_mem[ch_q][idx];
          gc_q    <= g_q[ch_q];
          state_q <= S_MUL;
        end
        S_MUL: begin
          // gc_q never exceeds ONE, so ONE - gc_q cannot underflow.
          p_q     <= (2*W)'(a_q) * (2*W)'(ONE - gc_q);
          q_q     <= (2*W)'(b_q) * (2*W)'(gc_q);
          state_q <= S_UPD;
        end
        S_UPD: begin
          g_q[ch_q] <= g_new;
          if (ch_q == CHW'(N_CH - 1)) begin
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            ch_q    <= ch_q + 1'b1;
            state_q <= S_LOOKUP;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.g_out = g_q;
endmodule

// File: tb/tb_hh_gating_engine.sv
module tb_hh_gating_engine;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hh_gating_if #(.W(16), .N_CH(4), .LUT_BITS(6)) b0 ();
  hh_gating_if #(.W(16), .N_CH(4), .LUT_BITS(6)) b1 ();

  hh_gating_engine #(.DT_SHIFT(4)) u0 (.clk(clk), .rst(rst), .bus(b0));
  hh_gating_engine #(.DT_SHIFT(0)) u1 (.clk(clk), .rst(rst), .bus(b1));

  int tests = 0;
  int fails = 0;

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] g0(input int c);
    return b0.g_out[c*16 +: 16];
  endfunction

  task automatic wr0(input logic [1:0] sel, input int ch, input int addr, input logic [15:0] data);
    b0.cfg_we = 1'b1; b0.cfg_sel = sel; b0.cfg_ch = 2'(ch);
    b0.cfg_addr = 6'(addr); b0.cfg_data = data;
    tick;
    b0.cfg_we = 1'b0;
  endtask

  task automatic start0(input logic signed [15:0] v);
    b0.start = 1'b1; b0.v_in = v;
    tick;
    b0.start = 1'b0;
  endtask

  // Bounded wait for done, then one more cycle so the engine is back in IDLE.
  task automatic wait_done0;
    int n = 0;
    while (b0.done !== 1'b1 && n < 40) begin tick; n++; end
    chk("done_seen", 64'(n < 40), 64'd1);
    tick;
  endtask

  task automatic step0(input logic signed [15:0] v);
    start0(v);
    wait_done0();
  endtask

  initial begin
    int ndone;
    b0.start = 0; b0.v_in = 0; b0.cfg_we = 0; b0.cfg_sel = 0; b0.cfg_ch = 0; b0.cfg_addr = 0; b0.cfg_data = 0;
    b1.start = 0; b1.v_in = 0; b1.cfg_we = 0; b1.cfg_sel = 0; b1.cfg_ch = 0; b1.cfg_addr = 0; b1.cfg_data = 0;
    rst = 1'b1;
    tick; tick;
    rst = 1'b0;
    tick;

    // Reset state
    chk("rst_gout", 64'(b0.g_out), 64'd0);
    chk("rst_busy", 64'(b0.busy), 64'd0);
    chk("rst_done", 64'(b0.done), 64'd0);

    // Tables: ch0 rise, ch1 decay, ch2 zero, ch3 distinct alpha per entry
    for (int e = 0; e < 64; e++) begin
      wr0(2'd0, 0, e, 16'd4096);  wr0(2'd1, 0, e, 16'd0);
      wr0(2'd0, 1, e, 16'd0);     wr0(2'd1, 1, e, 16'd65535);
      wr0(2'd0, 2, e, 16'd0);     wr0(2'd1, 2, e, 16'd0);
      wr0(2'd0, 3, e, 16'((e + 1) * 16)); wr0(2'd1, 3, e, 16'd0);
    end
    wr0(2'd2, 1, 0, 16'd10);
    chk("gwr_visible", 64'(g0(1)), 64'd10);
    wr0(2'd2, 2, 0, 16'd5000);
    chk("gwr_clamp", 64'(g0(2)), 64'd4096);
    wr0(2'd2, 2, 0, 16'd0);
    wr0(2'd3, 2, 0, 16'd123);
    chk("sel3_ignored", 64'(g0(2)), 64'd0);

    // Rise / decay with exact timing; start accepted at edge k
    start0(16'sd0);
    chk("busy_k", 64'(b0.busy), 64'd1);
    tick; tick;
    chk("g0_pre_k3", 64'(g0(0)), 64'd0);
    tick;
    chk("g0_k3", 64'(g0(0)), 64'd256);
    tick; tick; tick;
    chk("g1_decay_k6", 64'(g0(1)), 64'd0);
    repeat (5) tick;
    chk("done_k11", 64'(b0.done), 64'd0);
    tick;
    chk("done_k12", 64'(b0.done), 64'd1);
    chk("busy_k12", 64'(b0.busy), 64'd1);
    tick;
    chk("done_k13", 64'(b0.done), 64'd0);
    chk("busy_k13", 64'(b0.busy), 64'd0);

    step0(16'sd0);
    chk("g0_second", 64'(g0(0)), 64'd496);
    chk("g1_nowrap", 64'(g0(1)), 64'd0);

    // Index clamp via ch3 (g3 result = entry + 1)
    wr0(2'd2, 3, 0, 16'd0); step0(-16'sd200);
    chk("idx_m200", 64'(g0(3)), 64'd1);
    wr0(2'd2, 3, 0, 16'd0); step0(16'sd300);
    chk("idx_p300", 64'(g0(3)), 64'd64);
    wr0(2'd2, 3, 0, 16'd0); step0(-16'sd78);
    chk("idx_m78", 64'(g0(3)), 64'd1);
    wr0(2'd2, 3, 0, 16'd0); step0(-16'sd76);
    chk("idx_m76", 64'(g0(3)), 64'd2);
    wr0(2'd2, 3, 0, 16'd0); step0(16'sd0);
    chk("idx_0", 64'(g0(3)), 64'd21);

    // start with simultaneous g write: 32*(4096-100)>>16 = 1 -> 101
    b0.cfg_we = 1; b0.cfg_sel = 2'd2; b0.cfg_ch = 2'd3; b0.cfg_data = 16'd100;
    start0(-16'sd76);
    b0.cfg_we = 0;
    wait_done0();
    chk("start_with_gwr", 64'(g0(3)), 64'd101);

    // start / cfg_we while busy are ignored
    wr0(2'd2, 3, 0, 16'd0);
    start0(-16'sd76);
    b0.start = 1; b0.cfg_we = 1; b0.cfg_sel = 2'd0; b0.cfg_ch = 2'd3; b0.cfg_addr = 6'd1; b0.cfg_data = 16'd0;
    tick;
    b0.start = 0; b0.cfg_we = 0;
    tick; tick;
    b0.cfg_we = 1; b0.cfg_sel = 2'd2; b0.cfg_ch = 2'd3; b0.cfg_data = 16'd777;
    tick;
    b0.cfg_we = 0;
    ndone = 0;
    for (int i = 0; i < 30; i++) begin
      if (b0.done === 1'b1) ndone++;
      tick;
    end
    chk("busy_one_done", 64'(ndone), 64'd1);
    chk("busy_gwr_ignored", 64'(g0(3)), 64'd2);
    chk("busy_idle_after", 64'(b0.busy), 64'd0);
    step0(-16'sd76);
    chk("busy_lut_unchanged", 64'(g0(3)), 64'd3);

    // Reset mid-step (after writes)
    wr0(2'd2, 1, 0, 16'd10);
    start0(16'sd0);
    repeat (4) tick;
    rst = 1'b1;
    #1;
    chk("midrst_async_busy", 64'(b0.busy), 64'd0);
    chk("midrst_async_gout", 64'(b0.g_out), 64'd0);
    tick;
    rst = 1'b0;
    tick;
    chk("midrst_busy", 64'(b0.busy), 64'd0);
    chk("midrst_gout", 64'(b0.g_out), 64'd0);
    ndone = 0;
    for (int i = 0; i < 20; i++) begin
      if (b0.done === 1'b1) ndone++;
      tick;
    end
    chk("midrst_no_done", 64'(ndone), 64'd0);
    chk("midrst_gout_hold", 64'(b0.g_out), 64'd0);

    // Saturation on the DT_SHIFT=0 build: step = 65535 clamps to ONE
    for (int e = 0; e < 64; e++) begin
      b1.cfg_we = 1; b1.cfg_ch = 2'd2; b1.cfg_addr = 6'(e);
      b1.cfg_sel = 2'd0; b1.cfg_data = 16'd65535; tick;
      b1.cfg_sel = 2'd1; b1.cfg_data = 16'd0;     tick;
    end
    b1.cfg_we = 0;
    b1.start = 1; b1.v_in = 16'sd0;
    tick;
    b1.start = 0;
    begin
      int n = 0;
      while (b1.done !== 1'b1 && n < 40) begin tick; n++; end
      chk("sat_done_seen", 64'(n < 40), 64'd1);
    end
    chk("sat_g2", 64'(b1.g_out[2*16 +: 16]), 64'd4096);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
